// File: rtl/master_bridge_async_fifo_wr_bank_if.sv
// Write-bank bus: write request, read-side pointer/data exchange and per-channel status.
// Pointer vectors are packed [NUM_CH-1:0][PW-1:0], so channel 0 sits in the LSBs.
interface master_bridge_async_fifo_wr_bank_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int NUM_CH     = 2
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW   = ADDR_WIDTH + 1;

  logic                           i_wr_valid;
  logic [CH_W-1:0]                i_wr_ch;
  logic [DATA_WIDTH-1:0]          i_wr_data;
  logic [NUM_CH-1:0][PW-1:0]      i_rd_gray_ptr;
  logic [CH_W-1:0]                i_rd_ch;
  logic [ADDR_WIDTH-1:0]          i_rd_addr;
  logic [DATA_WIDTH-1:0]          o_rd_data;
  logic [NUM_CH-1:0][PW-1:0]      o_wr_gray_ptr;
  logic [NUM_CH-1:0]              o_full;
  logic [NUM_CH-1:0]              o_almost_full;
  logic [NUM_CH-1:0]              o_ovf_err;

  modport slave (
    input  i_wr_valid, i_wr_ch, i_wr_data, i_rd_gray_ptr, i_rd_ch, i_rd_addr,
    output o_rd_data, o_wr_gray_ptr, o_full, o_almost_full, o_ovf_err
  );

  modport master (
    output i_wr_valid, i_wr_ch, i_wr_data, i_rd_gray_ptr, i_rd_ch, i_rd_addr,
    input  o_rd_data, o_wr_gray_ptr, o_full, o_almost_full, o_ovf_err
  );
endinterface

// File: rtl/master_bridge_async_fifo_wr_bank.sv
// Write-domain half of the multi-channel async FIFO: one circular queue per channel,
// each with its own storage slice, Gray write pointer, read-pointer synchroniser and flags.
module master_bridge_async_fifo_wr_bank_ch #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 3,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 6
) (
  input  logic                  CLK,
  input  logic                  i_w_n_rst,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [ADDR_WIDTH:0]   i_rd_gray,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic [ADDR_WIDTH:0]   o_wr_gray,
  output logic                  o_full,
  output logic                  o_almost_full,
  output logic                  o_ovf_err
);
  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0][DATA_WIDTH-1:0]  mem_q, mem_d;
  logic [PW-1:0]                     wbin_q, wbin_d, wgray_q, wgray_d;
  logic [SYNC_STAGES-1:0][PW-1:0]    sync_q, sync_d;
  logic [PW-1:0]                     rsync_bin, fill;
  logic                              full_q, full_d, afull_q, afull_d, ovf_q, ovf_d;
  logic                              accept;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  always_comb begin
    accept = i_wr_en && !full_q;
    mem_d  = mem_q;
    if (accept) mem_d[wbin_q[ADDR_WIDTH-1:0]] = i_wr_data;
    wbin_d  = wbin_q + {{(PW-1){1'b0}}, accept};
    wgray_d = wbin_d ^ (wbin_d >> 1);
    sync_d[0] = i_rd_gray;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    // Flags look at the post-update write pointer so full lands on the DEPTH-th write's edge.
    // fill == DEPTH is the same test as Gray(wptr) == rsync with its top two bits inverted.
    rsync_bin = gray2bin(sync_q[SYNC_STAGES-1]);
    fill      = wbin_d - rsync_bin;
    full_d    = (fill == PW'(DEPTH));
    afull_d   = (fill >= PW'(AFULL_THRESH));
    ovf_d     = ovf_q | (i_wr_en && full_q);
  end

  always_ff @(posedge CLK or negedge i_w_n_rst) begin
    if (!i_w_n_rst) begin
      mem_q   <= '0;
      wbin_q  <= '0;
      wgray_q <= '0;
      sync_q  <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      sync_q  <= sync_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_rd_data     = mem_q[i_rd_addr];
  assign o_wr_gray     = wgray_q;
  assign o_full        = full_q;
  assign o_almost_full = afull_q;
  assign o_ovf_err     = ovf_q;
endmodule

module master_bridge_async_fifo_wr_bank #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 3,
  parameter int NUM_CH       = 2,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 6
) (
  input  logic CLK,
  input  logic i_w_n_rst,
  master_bridge_async_fifo_wr_bank_if.slave bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW   = ADDR_WIDTH + 1;

  logic [NUM_CH-1:0][DATA_WIDTH-1:0] ch_rd_data;
  logic [NUM_CH-1:0][PW-1:0]         ch_wr_gray;
  logic [NUM_CH-1:0]                 ch_full, ch_afull, ch_ovf;
  logic [DATA_WIDTH-1:0]             rd_data;

  // Channel codes >= NUM_CH match no instance, so such writes are silently dropped.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    master_bridge_async_fifo_wr_bank_ch #(
      .DATA_WIDTH  (DATA_WIDTH),
      .ADDR_WIDTH  (ADDR_WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .AFULL_THRESH(AFULL_THRESH)
    ) u_ch (
      .CLK          (CLK),
      .i_w_n_rst    (i_w_n_rst),
      .i_wr_en      (bus.i_wr_valid && (bus.i_wr_ch == CH_W'(c))),
      .i_wr_data    (bus.i_wr_data),
      .i_rd_gray    (bus.i_rd_gray_ptr[c]),
      .i_rd_addr    (bus.i_rd_addr),
      .o_rd_data    (ch_rd_data[c]),
      .o_wr_gray    (ch_wr_gray[c]),
      .o_full       (ch_full[c]),
      .o_almost_full(ch_afull[c]),
      .o_ovf_err    (ch_ovf[c])
    );
  end

  always_comb begin
    rd_data = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (bus.i_rd_ch == CH_W'(c)) rd_data = ch_rd_data[c];
  end

  assign bus.o_rd_data     = rd_data;
  assign bus.o_wr_gray_ptr = ch_wr_gray;
  assign bus.o_full        = ch_full;
  assign bus.o_almost_full = ch_afull;
  assign bus.o_ovf_err     = ch_ovf;
endmodule
